// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared parameters and types for the issue scoreboard
//
// Purpose: default configuration of the scoreboard, the pending-counter type
// and the register-address type used across the scoreboard files.
// Ports:   none (package).
package issue_scoreboard_pkg;

    localparam int SB_NREG = 32;  // architectural GPRs
    localparam int SB_AW   = 5;   // register address width
    localparam int SB_NSRC = 2;   // source operands per instruction
    localparam int SB_NWB  = 2;   // writeback/cancel ports
    localparam int SB_CW   = 2;   // pending-counter width
    localparam int SB_PW   = 64;  // opaque payload width

    typedef logic [SB_CW-1:0] sb_cnt_t;
    typedef logic [SB_AW-1:0] creg_addr_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// rtl/issue_scoreboard_if.sv - decode/execute/writeback bundle of the issue scoreboard
//
// Purpose: groups the instruction-in handshake, the registered out stage,
//          the release ports and the status flags.
// Modports:
//   master - decode/execute/writeback side (drives in_*, out_ready, wb_*, csr_done, flush)
//   slave  - the scoreboard (drives in_ready, out_*, stall_raw, sb_err)
interface issue_scoreboard_if
    import issue_scoreboard_pkg::*;
#(
    parameter int AW   = SB_AW,
    parameter int NSRC = SB_NSRC,
    parameter int NWB  = SB_NWB,
    parameter int PW   = SB_PW
) ();

    logic                in_valid;
    logic                in_ready;
    logic [NSRC*AW-1:0]  in_rs;
    logic [NSRC-1:0]     in_rs_used;
    logic [AW-1:0]       in_rd;
    logic                in_rd_we;
    logic                in_csr_rd;
    logic                in_csr_we;
    logic [PW-1:0]       in_payload;

    logic                out_valid;
    logic                out_ready;
    logic [PW-1:0]       out_payload;
    logic [AW-1:0]       out_rd;
    logic                out_rd_we;
    logic                out_csr_we;

    logic [NWB-1:0]      wb_valid;
    logic [NWB*AW-1:0]   wb_addr;
    logic                csr_done;
    logic                flush;

    logic                stall_raw;
    logic                sb_err;

    modport master (
        output in_valid, in_rs, in_rs_used, in_rd, in_rd_we, in_csr_rd, in_csr_we, in_payload,
        output out_ready, wb_valid, wb_addr, csr_done, flush,
        input  in_ready, out_valid, out_payload, out_rd, out_rd_we, out_csr_we,
        input  stall_raw, sb_err
    );

    modport slave (
        input  in_valid, in_rs, in_rs_used, in_rd, in_rd_we, in_csr_rd, in_csr_we, in_payload,
        input  out_ready, wb_valid, wb_addr, csr_done, flush,
        output in_ready, out_valid, out_payload, out_rd, out_rd_we, out_csr_we,
        output stall_raw, sb_err
    );

endinterface

// File: rtl/issue_scoreboard_sb_cnt_bank.sv
// rtl/issue_scoreboard_sb_cnt_bank.sv - per-register pending-write counters
//
// Purpose: NREG saturating-free up/down counters, one increment port, one
//          undo port and NWB release ports, all applied in the same edge.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_inc_valid/i_inc_addr     count one new in-flight write
//   i_undo_valid/i_undo_addr   take back a squashed increment
//   i_wb_valid/i_wb_addr       NWB release ports (writeback or cancel)
//   o_cnt                      registered counts
//   o_err                      this cycle's release underflowed or targeted x0
module sb_cnt_bank
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG = SB_NREG,
    parameter int AW   = SB_AW,
    parameter int NWB  = SB_NWB,
    parameter int CW   = SB_CW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_inc_valid,
    input  logic [AW-1:0]      i_inc_addr,
    input  logic               i_undo_valid,
    input  logic [AW-1:0]      i_undo_addr,
    input  logic [NWB-1:0]     i_wb_valid,
    input  logic [NWB*AW-1:0]  i_wb_addr,
    output logic [CW-1:0]      o_cnt [NREG],
    output logic               o_err
);

    // Wide enough for cnt+1 and for NWB release hits plus the undo hit.
    localparam int DW = ((CW > $clog2(NWB + 2)) ? CW : $clog2(NWB + 2)) + 1;

    logic [CW-1:0]   r_cnt     [NREG];
    logic [CW-1:0]   w_cnt_nxt [NREG];
    logic [DW-1:0]   w_sum     [NREG];
    logic [DW-1:0]   w_dec     [NREG];
    logic [NREG-1:0] w_under;
    logic            w_x0_rel;

    always_comb begin
        w_x0_rel = 1'b0;
        for (int p = 0; p < NWB; p++) begin
            if (i_wb_valid[p] && (i_wb_addr[p*AW +: AW] == '0)) begin
                w_x0_rel = 1'b1;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_sum[r] = {{(DW-CW){1'b0}}, r_cnt[r]}
                     + DW'(i_inc_valid && (i_inc_addr == AW'(r)));
            w_dec[r] = DW'(i_undo_valid && (i_undo_addr == AW'(r)));
            for (int p = 0; p < NWB; p++) begin
                w_dec[r] = w_dec[r] + DW'(i_wb_valid[p] && (i_wb_addr[p*AW +: AW] == AW'(r)));
            end
            if (r == 0) begin
                // x0 is never tracked; a release of it is flagged via w_x0_rel.
                w_cnt_nxt[r] = '0;
                w_under[r]   = 1'b0;
            end else if (w_sum[r] < w_dec[r]) begin
                w_cnt_nxt[r] = '0;
                w_under[r]   = 1'b1;
            end else begin
                w_cnt_nxt[r] = CW'(w_sum[r] - w_dec[r]);
                w_under[r]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_err = w_x0_rel | (|w_under);

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order issue stage with RAW/WAW-saturation/CSR hazard scoreboard
//
// Purpose: accepts decoded instructions, stalls them while a source register
//          or the CSR file has an in-flight write, and presents accepted
//          instructions through a one-entry registered out stage.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-low reset
//   bus    issue_scoreboard_if.slave (in_*, out_*, wb_*, csr_done, flush,
//          stall_raw, sb_err)
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG = SB_NREG,
    parameter int AW   = SB_AW,
    parameter int NSRC = SB_NSRC,
    parameter int NWB  = SB_NWB,
    parameter int CW   = SB_CW,
    parameter int PW   = SB_PW
) (
    input  logic              clk,
    input  logic              reset,
    issue_scoreboard_if.slave bus
);

    localparam int CSW = CW + 1;

    logic [CW-1:0]  w_cnt [NREG];
    logic [CW-1:0]  r_csr_cnt;
    logic [CW-1:0]  w_csr_nxt;
    logic [CSW-1:0] w_csr_sum;
    logic [CSW-1:0] w_csr_dec;
    logic           w_csr_err;

    logic           r_out_valid;
    logic [PW-1:0]  r_out_payload;
    logic [AW-1:0]  r_out_rd;
    logic           r_out_rd_we;
    logic           r_out_csr_we;
    logic           r_sb_err;

    logic           w_hazard;
    logic           w_ready;
    logic           w_accept;
    logic           w_inc;
    logic           w_undo;
    logic           w_undo_rd;
    logic           w_undo_csr;
    logic           w_bank_err;

    // Hazards look only at registered counts, so a release becomes visible
    // to a dependent instruction one cycle later.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.in_rs_used[i] && (bus.in_rs[i*AW +: AW] != '0)
                && (w_cnt[bus.in_rs[i*AW +: AW]] != '0)) begin
                w_hazard = 1'b1;
            end
        end
        if ((bus.in_csr_rd || bus.in_csr_we) && (r_csr_cnt != '0)) begin
            w_hazard = 1'b1;
        end
        // A writer to a saturated counter would wrap it; hold it back.
        if (bus.in_rd_we && (bus.in_rd != '0) && (&w_cnt[bus.in_rd])) begin
            w_hazard = 1'b1;
        end
        if (bus.in_csr_we && (&r_csr_cnt)) begin
            w_hazard = 1'b1;
        end
    end

    // reset gates in_ready combinationally so it is low for the whole reset window.
    assign w_ready  = reset & ~w_hazard & ~bus.flush & (~r_out_valid | bus.out_ready);
    assign w_accept = bus.in_valid & w_ready;
    assign w_inc    = w_accept & bus.in_rd_we & (bus.in_rd != '0);

    // A flushed entry that execute never took must give back its increments.
    assign w_undo     = bus.flush & r_out_valid & ~bus.out_ready;
    assign w_undo_rd  = w_undo & r_out_rd_we & (r_out_rd != '0);
    assign w_undo_csr = w_undo & r_out_csr_we;

    sb_cnt_bank #(
        .NREG (NREG),
        .AW   (AW),
        .NWB  (NWB),
        .CW   (CW)
    ) u_cnt_bank (
        .clk          (clk),
        .rst_n        (reset),
        .i_inc_valid  (w_inc),
        .i_inc_addr   (bus.in_rd),
        .i_undo_valid (w_undo_rd),
        .i_undo_addr  (r_out_rd),
        .i_wb_valid   (bus.wb_valid),
        .i_wb_addr    (bus.wb_addr),
        .o_cnt        (w_cnt),
        .o_err        (w_bank_err)
    );

    always_comb begin
        w_csr_sum = {1'b0, r_csr_cnt} + CSW'(w_accept & bus.in_csr_we);
        w_csr_dec = CSW'(w_undo_csr) + CSW'(bus.csr_done);
        if (w_csr_sum < w_csr_dec) begin
            w_csr_nxt = '0;
            w_csr_err = 1'b1;
        end else begin
            w_csr_nxt = CW'(w_csr_sum - w_csr_dec);
            w_csr_err = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_csr_cnt <= '0;
            r_sb_err  <= 1'b0;
        end else begin
            r_csr_cnt <= w_csr_nxt;
            r_sb_err  <= r_sb_err | w_bank_err | w_csr_err;
        end
    end

    // Out stage: load on accept (only possible when empty or being drained),
    // otherwise empty on consume or flush; fields hold while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_payload <= '0;
            r_out_rd      <= '0;
            r_out_rd_we   <= 1'b0;
            r_out_csr_we  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_payload <= bus.in_payload;
            r_out_rd      <= bus.in_rd;
            r_out_rd_we   <= bus.in_rd_we;
            r_out_csr_we  <= bus.in_csr_we;
        end else if (bus.flush || bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.stall_raw   = bus.in_valid & w_hazard;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_payload = r_out_payload;
    assign bus.out_rd      = r_out_rd;
    assign bus.out_rd_we   = r_out_rd_we;
    assign bus.out_csr_we  = r_out_csr_we;
    assign bus.sb_err      = r_sb_err;

endmodule
